// File: rtl/cfg_pkg.sv
// Shared definitions for the serial configuration loader.
// Holds the loader FSM state type, the CRC-8 constants, the default sync
// word and the bit-serial CRC-8 next-state function.
package cfg_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StLoad,
        StCheck,
        StCommit
    } cfg_state_e;

    localparam logic [7:0]  CRC_POLY          = 8'h07;
    localparam int unsigned CRC_W             = 8;
    localparam logic [7:0]  SYNC_WORD_DEFAULT = 8'hA5;

    // One step of CRC-8 (x^8+x^2+x+1), MSB-first, no reflection.
    function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator.
// Ports:
//   clk_i     - clock, rising edge
//   reset_i   - synchronous active-high reset, CRC -> 0x00
//   clear_i   - synchronous clear to 0x00 (wins over enable_i)
//   enable_i  - fold bit_i into the CRC this cycle
//   bit_i     - serial data bit
//   crc_o     - current CRC value
module crc8_serial
    import cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (enable_i) begin
            crc_d = crc8_next(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader for the cell array.
// Hunts a 1-bit valid/ready stream for a sync word, shifts CFG_WIDTH payload
// bits into a shadow register, receives an 8-bit CRC and commits the shadow
// to config_bit_o only when the CRC matches. Holds the cell array in reset
// while no verified configuration is present or a load is in progress.
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - synchronous active-high reset
//   cfg_data_i   - serial configuration bit
//   cfg_valid_i  - cfg_data_i valid this cycle
//   cfg_ready_o  - loader accepts a bit this cycle (low only in COMMIT)
//   cfg_abort_i  - synchronous abort of the current frame
//   config_bit_o - committed configuration vector
//   cfg_loaded_o - config_bit_o holds a CRC-verified frame
//   cfg_done_o   - one-cycle pulse on successful commit
//   cfg_err_o    - one-cycle pulse on CRC mismatch
//   busy_o       - FSM is not hunting for sync
//   cell_reset_o - registered reset for the cell array
module config_loader
    import cfg_pkg::*;
#(
    parameter int unsigned CFG_WIDTH = 124,
    parameter logic [7:0]  SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cfg_data_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic                 cfg_abort_i,
    output logic [CFG_WIDTH-1:0] config_bit_o,
    output logic                 cfg_loaded_o,
    output logic                 cfg_done_o,
    output logic                 cfg_err_o,
    output logic                 busy_o,
    output logic                 cell_reset_o
);

    cfg_state_e           state_q, state_d;
    logic [7:0]           window_q, window_d;
    logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
    logic [6:0]           cnt_q, cnt_d;
    logic [CRC_W-1:0]     rx_crc_q, rx_crc_d;
    logic [CFG_WIDTH-1:0] config_q, config_d;
    logic                 loaded_q, loaded_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 cell_reset_q, cell_reset_d;

    logic                 accept;
    logic [7:0]           window_shift;
    logic                 crc_clear;
    logic                 crc_en;
    logic [CRC_W-1:0]     crc_calc;

    assign cfg_ready_o  = (state_q != StCommit);
    assign accept       = cfg_valid_i && cfg_ready_o;
    assign window_shift = {window_q[6:0], cfg_data_i};

    crc8_serial u_crc (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (crc_clear),
        .enable_i (crc_en),
        .bit_i    (cfg_data_i),
        .crc_o    (crc_calc)
    );

    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        rx_crc_d  = rx_crc_q;
        config_d  = config_q;
        loaded_d  = loaded_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        crc_clear = 1'b0;
        crc_en    = 1'b0;

        if (cfg_abort_i) begin
            // Abort wins over everything in the data path, including a commit.
            state_d   = StHunt;
            window_d  = '0;
            shadow_d  = '0;
            cnt_d     = '0;
            rx_crc_d  = '0;
            crc_clear = 1'b1;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (accept) begin
                        window_d = window_shift;
                        if (window_shift == SYNC_WORD) begin
                            state_d   = StLoad;
                            cnt_d     = '0;
                            shadow_d  = '0;
                            crc_clear = 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        // Right shift: the first payload bit ends up in bit 0.
                        shadow_d = {cfg_data_i, shadow_q[CFG_WIDTH-1:1]};
                        crc_en   = 1'b1;
                        if (cnt_q == 7'(CFG_WIDTH - 1)) begin
                            state_d = StCheck;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                StCheck: begin
                    if (accept) begin
                        rx_crc_d = {rx_crc_q[CRC_W-2:0], cfg_data_i};
                        if (cnt_q == 7'(CRC_W - 1)) begin
                            state_d = StCommit;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                StCommit: begin
                    if (crc_calc == rx_crc_q) begin
                        config_d = shadow_q;
                        loaded_d = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d  = StHunt;
                    window_d = '0;
                end
                default: begin
                    state_d  = StHunt;
                    window_d = '0;
                end
            endcase
        end

        // Uses current registered state, so the cell array leaves reset one
        // cycle after the FSM is back in HUNT with a verified config.
        cell_reset_d = !loaded_q || (state_q != StHunt);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StHunt;
            window_q     <= '0;
            shadow_q     <= '0;
            cnt_q        <= '0;
            rx_crc_q     <= '0;
            config_q     <= '0;
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cell_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            rx_crc_q     <= rx_crc_d;
            config_q     <= config_d;
            loaded_q     <= loaded_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cell_reset_q <= cell_reset_d;
        end
    end

    assign config_bit_o = config_q;
    assign cfg_loaded_o = loaded_q;
    assign cfg_done_o   = done_q;
    assign cfg_err_o    = err_q;
    assign busy_o       = (state_q != StHunt);
    assign cell_reset_o = cell_reset_q;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: frames are driven bit by bit, each
// frame's expected commit/error outcome is queued by the driver, and a
// monitor pops and compares on every cfg_done/cfg_err pulse.
module tb_config_loader;

    localparam int unsigned W = 124;

    logic         clk;
    logic         reset;
    logic         cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_abort;
    logic [W-1:0] config_bit;
    logic         cfg_loaded;
    logic         cfg_done;
    logic         cfg_err;
    logic         busy;
    logic         cell_reset;

    config_loader #(
        .CFG_WIDTH (W),
        .SYNC_WORD (8'hA5)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cfg_data_i   (cfg_data),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_abort_i  (cfg_abort),
        .config_bit_o (config_bit),
        .cfg_loaded_o (cfg_loaded),
        .cfg_done_o   (cfg_done),
        .cfg_err_o    (cfg_err),
        .busy_o       (busy),
        .cell_reset_o (cell_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           is_err;
        logic [W-1:0] cfg;
        bit           loaded;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_cfg    = '0;
    bit           model_loaded = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC: remainder of payload(x) * x^8 divided by x^8+x^2+x+1,
    // with the first transmitted bit as the highest-order coefficient.
    function automatic logic [7:0] model_crc(input logic [W-1:0] p);
        logic [W+7:0] m;
        m = '0;
        for (int k = 0; k < W; k++) m[W+7-k] = p[k];
        for (int k = 0; k < W; k++) begin
            if (m[W+7-k]) m[W+7-k -: 9] = m[W+7-k -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    task automatic send_bit(input logic b, input int gap);
        logic r;
        int   n;
        if (gap > 0) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(99) >= gap) break;
                cfg_valid = 1'b0;
                cfg_data  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        cfg_data  = b;
        cfg_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            r = cfg_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 20) begin
                tests++;
                fails++;
                $display("FAIL ready_timeout: cfg_ready stayed %0b, required 1", r);
                break;
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_payload(input logic [W-1:0] p, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) send_bit(p[i], gap);
    endtask

    task automatic send_frame(input logic [W-1:0] p, input logic [7:0] crc, input int gap);
        exp_t e;
        bit   good;
        good = (crc == model_crc(p));
        if (good) begin
            model_cfg    = p;
            model_loaded = 1'b1;
        end
        e.is_err = !good;
        e.cfg    = model_cfg;
        e.loaded = model_loaded;
        exp_q.push_back(e);
        send_byte(8'hA5, gap);
        send_payload(p, W, gap);
        send_byte(crc, gap);
    endtask

    function automatic logic [W-1:0] rand_payload();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Monitor: every pulse must match the oldest queued expectation, and
    // cfg_ready may be low only in the cycle right before a pulse.
    int pulse_cyc = -1;
    initial begin
        bit   prev_ready_low;
        exp_t e;
        prev_ready_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cfg_done || cfg_err) begin
                    pulse_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse: done=%0b err=%0b, required none",
                                 cfg_done, cfg_err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_is_err", {cfg_done, cfg_err}, {!e.is_err, e.is_err});
                        chk("commit_config_bit", config_bit, e.cfg);
                        chk("commit_cfg_loaded", cfg_loaded, e.loaded);
                        chk("cell_reset_at_pulse", cell_reset, 1'b1);
                        chk("busy_at_pulse", busy, 1'b0);
                    end
                end
                if (prev_ready_low || cfg_done || cfg_err) begin
                    chk("ready_low_only_in_commit", prev_ready_low, cfg_done || cfg_err);
                end
            end
            prev_ready_low = !cfg_ready && !reset;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int           e0;
        logic [W-1:0] p;
        logic [7:0]   c;

        reset     = 1'b1;
        cfg_data  = 1'b0;
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_config_bit", config_bit, '0);
        chk("rst_cfg_loaded", cfg_loaded, 1'b0);
        chk("rst_cfg_done", cfg_done, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cell_reset", cell_reset, 1'b1);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e0 = cyc;

        // All-zero payload, correct CRC 0x00, continuous valid.
        send_frame('0, 8'h00, 0);
        @(negedge clk);
        chk("commit_cycle_ready", cfg_ready, 1'b0);
        chk("commit_cycle_done", cfg_done, 1'b0);
        chk("commit_cycle_busy", busy, 1'b1);
        @(negedge clk);
        chk("done_pulse", cfg_done, 1'b1);
        chk("done_edge", pulse_cyc, e0 + 141);
        @(negedge clk);
        chk("done_single_cycle", cfg_done, 1'b0);
        chk("cell_reset_falls", cell_reset, 1'b0);
        chk("loaded_after_done", cfg_loaded, 1'b1);

        // Same frame with a wrong CRC: error pulse, previous config kept.
        @(posedge clk);
        #1;
        send_frame('0, 8'h01, 0);
        repeat (3) @(negedge clk);
        chk("err_back_to_hunt", busy, 1'b0);
        chk("err_keeps_loaded", cfg_loaded, 1'b1);
        chk("err_keeps_config", config_bit, '0);

        // Near-miss junk before the sync word, payload bit0 = 1.
        @(posedge clk);
        #1;
        send_byte(8'hA4, 0);
        send_byte(8'h4A, 0);
        p = '0;
        p[0] = 1'b1;
        send_frame(p, model_crc(p), 0);
        repeat (3) @(negedge clk);
        chk("junk_then_frame_config", config_bit, p);

        // Random payloads with ~50% valid gaps, some CRCs corrupted.
        for (int f = 0; f < 5; f++) begin
            @(posedge clk);
            #1;
            p = rand_payload();
            c = model_crc(p);
            if ($urandom_range(3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_frame(p, c, 50);
            repeat (3) @(negedge clk);
            chk("random_frame_config", config_bit, model_cfg);
        end

        // Make sure a verified config is present, then abort mid-payload.
        @(posedge clk);
        #1;
        p = rand_payload();
        send_frame(p, model_crc(p), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        send_byte(8'hA5, 30);
        send_payload(rand_payload(), 60, 30);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 1'($urandom);
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("abort_to_hunt", busy, 1'b0);
        chk("abort_keeps_config", config_bit, model_cfg);
        chk("abort_keeps_loaded", cfg_loaded, 1'b1);
        @(negedge clk);
        chk("abort_cell_reset_drops", cell_reset, 1'b0);
        @(posedge clk);
        #1;
        p = rand_payload();
        send_frame(p, model_crc(p), 40);
        repeat (3) @(negedge clk);
        chk("after_abort_config", config_bit, p);

        // Reset in the middle of LOAD discards everything.
        @(posedge clk);
        #1;
        send_byte(8'hA5, 0);
        send_payload(rand_payload(), 30, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_cfg    = '0;
        model_loaded = 1'b0;
        @(negedge clk);
        chk("midload_rst_config", config_bit, '0);
        chk("midload_rst_loaded", cfg_loaded, 1'b0);
        chk("midload_rst_busy", busy, 1'b0);
        chk("midload_rst_cell_reset", cell_reset, 1'b1);
        chk("midload_rst_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        p = rand_payload();
        send_frame(p, model_crc(p), 20);
        repeat (4) @(negedge clk);
        chk("post_reset_config", config_bit, p);
        chk("post_reset_cell_reset", cell_reset, 1'b0);

        chk("scoreboard_drained", 128'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
